// File: rtl/mod_digit_counter_if.sv
// Control and display signal bundle for mod_digit_counter.
// The master drives counting controls; the slave (the counter) returns digit, segments and wrap pulses.
interface mod_digit_counter_if;
    logic       tick;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] load_val;
    logic       blank;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       carry;
    logic       borrow;

    modport master (
        output tick, mode, dir, load_val, blank,
        input  digit, seg, carry, borrow
    );

    modport slave (
        input  tick, mode, dir, load_val, blank,
        output digit, seg, carry, borrow
    );
endinterface

// File: rtl/mod_digit_counter.sv
// Prescaled modulo-N up/down digit counter with clear/hold/load modes,
// wrap pulses and an active-low seven-segment decode with blanking.
module mod_digit_counter #(
    parameter int MODULO = 6,
    parameter int DIV    = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    mod_digit_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [3:0]     DIG_MAX   = 4'(MODULO - 1);
    localparam logic [4:0]     MOD_W     = 5'(MODULO);

    logic [PW-1:0] presc_q,  presc_d;
    logic [3:0]    digit_q,  digit_d;
    logic          carry_q,  carry_d;
    logic          borrow_q, borrow_d;

    mode_e mode;
    logic  step;
    logic  load_in_range;
    logic [6:0] seg_raw;

    assign mode          = mode_e'(bus.mode);
    assign step          = (mode == MODE_RUN) && bus.tick && (presc_q == PRESC_MAX);
    assign load_in_range = ({1'b0, bus.load_val} < MOD_W);

    always_comb begin
        presc_d  = presc_q;
        digit_d  = digit_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;

        unique case (mode)
            MODE_RUN: begin
                if (bus.tick) begin
                    if (step) begin
                        presc_d = '0;
                        if (!bus.dir) begin
                            if (digit_q == DIG_MAX) begin
                                digit_d = 4'd0;
                                carry_d = 1'b1;
                            end else begin
                                digit_d = digit_q + 4'd1;
                            end
                        end else begin
                            if (digit_q == 4'd0) begin
                                digit_d  = DIG_MAX;
                                borrow_d = 1'b1;
                            end else begin
                                digit_d = digit_q - 4'd1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            MODE_CLEAR: begin
                presc_d = '0;
                digit_d = 4'd0;
            end
            MODE_HOLD: begin
                presc_d = presc_q;
                digit_d = digit_q;
            end
            MODE_LOAD: begin
                // Out-of-range loads saturate so the digit can never leave 0..MODULO-1.
                presc_d = '0;
                digit_d = load_in_range ? bus.load_val : DIG_MAX;
            end
            default: begin
                presc_d = presc_q;
                digit_d = digit_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            digit_q  <= 4'd0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // Segment order is a..g from MSB to LSB; a 0 lights the segment.
    always_comb begin
        seg_raw = 7'b1111111;
        case (digit_q)
            4'h0: seg_raw = 7'b0000001;
            4'h1: seg_raw = 7'b1001111;
            4'h2: seg_raw = 7'b0010010;
            4'h3: seg_raw = 7'b0000110;
            4'h4: seg_raw = 7'b1001100;
            4'h5: seg_raw = 7'b0100100;
            4'h6: seg_raw = 7'b0100000;
            4'h7: seg_raw = 7'b0001111;
            4'h8: seg_raw = 7'b0000000;
            4'h9: seg_raw = 7'b0000100;
            4'hA: seg_raw = 7'b0001000;
            4'hB: seg_raw = 7'b1100000;
            4'hC: seg_raw = 7'b0110001;
            4'hD: seg_raw = 7'b1000010;
            4'hE: seg_raw = 7'b0110000;
            4'hF: seg_raw = 7'b0111000;
            default: seg_raw = 7'b1111111;
        endcase
    end

    assign bus.digit  = digit_q;
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
    assign bus.seg    = bus.blank ? 7'b1111111 : seg_raw;

endmodule

// File: doc/mod_digit_counter.md
MOD_DIGIT_COUNTER -- requirements
Module: mod_digit_counter

Interface
REQ-001 The block SHALL have parameter MODULO, default 6, giving the digit count range 0..MODULO-1; legal values are 2..16.
REQ-002 The block SHALL have parameter DIV, default 1, giving the number of qualified ticks per digit step; legal values are 1..2^16.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick, input, 1 bit: count enable, sampled on the clock edge.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 run, 01 clear, 10 hold, 11 load.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down.
REQ-008 The block SHALL have port load_val, input, 4 bits: value captured in load mode.
REQ-009 The block SHALL have port blank, input, 1 bit: forces the display segments off.
REQ-010 The block SHALL have port digit, output, 4 bits: current registered digit value.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments, seg[6]=a through seg[0]=g.
REQ-012 The block SHALL have port carry, output, 1 bit: one-cycle pulse on up-count wrap.
REQ-013 The block SHALL have port borrow, output, 1 bit: one-cycle pulse on down-count wrap.

Function
REQ-014 The block SHALL keep an internal prescaler presc that counts 0..DIV-1; its width is ceil(log2(DIV)), minimum 1 bit.
REQ-015 In run mode with tick=1, the block SHALL produce a step when presc==DIV-1 and reset presc to 0; otherwise it SHALL increment presc.
REQ-016 In run mode with tick=0, presc, digit, carry and borrow SHALL be held, with carry=borrow=0.
REQ-017 On an up step (dir=0), digit SHALL increment; when digit==MODULO-1 it SHALL wrap to 0 and assert carry=1 for exactly that one cycle.
REQ-018 On a down step (dir=1), digit SHALL decrement; when digit==0 it SHALL wrap to MODULO-1 and assert borrow=1 for exactly that one cycle.
REQ-019 The digit and carry/borrow SHALL update on the same clock edge, with zero added latency from the qualifying tick edge.
REQ-020 In clear mode, digit and presc SHALL go to 0 on the next edge, carry=borrow=0, and tick SHALL be ignored.
REQ-021 In hold mode, digit and presc SHALL be frozen, carry=borrow=0, and tick SHALL be ignored.
REQ-022 In load mode, digit SHALL take load_val when load_val<MODULO, else MODULO-1; presc SHALL go to 0, carry=borrow=0, and tick SHALL be ignored.
REQ-023 Mode SHALL take priority over tick in every cycle; a dir change takes effect on the next step only.
REQ-024 When DIV=1, every run-mode tick SHALL be a step.
REQ-025 seg SHALL be a combinational decode of digit, active-low, using the hex encodings below (abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
REQ-026 blank=1 SHALL force seg=1111111 without affecting any counting state.
REQ-027 digit SHALL never hold a value >= MODULO.

Reset
REQ-028 reset_n=0 SHALL immediately, without a clock, force digit=0, presc=0, carry=0 and borrow=0, so seg=0000001 unless blank=1.
REQ-029 Reset asserted mid-count SHALL discard any partial prescale, and the first step after release SHALL require a full DIV ticks.
REQ-030 Deassertion of reset_n SHALL be synchronised by the integrator; the block's first active edge follows deassertion.

Verification
REQ-031 MODULO=6, DIV=1, run, dir=0, tick=1 for 6 cycles -> digit 1,2,3,4,5,0; carry=1 only on the cycle digit becomes 0.
REQ-032 MODULO=10, DIV=3, run, dir=1, digit=0, tick held 1 -> digit=9 and borrow=1 after exactly 3 edges.
REQ-033 Load mode with load_val=12 and MODULO=10 -> digit=9, seg=0000100; load_val=4 -> digit=4, seg=1001100.
REQ-034 Hold mode with tick=1 for 20 cycles -> digit and presc unchanged, carry=0; then clear -> digit=0 next edge.
REQ-035 Run mode at digit=3 with presc=1 of DIV=3, reset_n pulsed low between edges -> digit=0 immediately, and the next step occurs after 3 ticks.
REQ-036 Run mode with blank=1 across a wrap -> seg=1111111 throughout while digit and carry behave per REQ-017.
